// File: rtl/csma_tx_scheduler_if.sv
// Host-side transmit handshake between the TX path and the CSMA/CA scheduler.
interface csma_tx_scheduler_if;
  logic       tx_req;
  logic       tx_done;
  logic       tx_fail;
  logic       tx_grant;
  logic       frame_drop;
  logic [3:0] retry_cnt;

  modport master (output tx_req, tx_done, tx_fail,
                  input  tx_grant, frame_drop, retry_cnt);
  modport slave  (input  tx_req, tx_done, tx_fail,
                  output tx_grant, frame_drop, retry_cnt);
endinterface

// File: rtl/csma_tx_scheduler.sv
// CSMA/CA transmit scheduler: DIFS idle wait, slotted random backoff with
// binary exponential contention window, retry/drop, and carrier-sense freeze during TX.
module csma_tx_scheduler #(
  parameter int unsigned SLOT_CYCLES = 200,
  parameter int unsigned DIFS_SLOTS  = 2,
  parameter int unsigned CW_MIN_EXP  = 4,
  parameter int unsigned CW_MAX_EXP  = 10,
  parameter int unsigned MAX_RETRIES = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 carrier_present,
  csma_tx_scheduler_if.slave   host,
  output logic                 cs_run,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIFS    = 2'd1,
    S_BACKOFF = 2'd2,
    S_TX      = 2'd3
  } state_e;

  localparam logic [31:0] DIFS_LAST = 32'(DIFS_SLOTS * SLOT_CYCLES - 1);
  localparam logic [15:0] SLOT_LAST = 16'(SLOT_CYCLES - 1);
  localparam logic [3:0]  CW_MIN    = 4'(CW_MIN_EXP);
  localparam logic [3:0]  CW_MAX    = 4'(CW_MAX_EXP);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      st_q, st_d;
  logic [3:0]  cw_q, cw_d, cw_inc;
  logic [9:0]  bo_q, bo_d;
  logic [31:0] difs_q, difs_d;
  logic [15:0] slot_q, slot_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] lfsr_q;
  logic        grant_q, csrun_q, drop_q, drop_d;

  // Window mask is 2^e-1 slots; e==10 covers the whole 10-bit draw.
  function automatic logic [9:0] draw(input logic [15:0] l, input logic [3:0] e);
    logic [9:0] m;
    m = ~(10'h3FF << e);
    return l[9:0] & m;
  endfunction

  always_comb begin
    st_d    = st_q;
    cw_d    = cw_q;
    bo_d    = bo_q;
    difs_d  = difs_q;
    slot_d  = slot_q;
    retry_d = retry_q;
    drop_d  = 1'b0;
    cw_inc  = (cw_q < CW_MAX) ? cw_q + 4'd1 : CW_MAX;
    if (!enable) begin
      st_d    = S_IDLE;
      cw_d    = CW_MIN;
      bo_d    = '0;
      difs_d  = '0;
      slot_d  = '0;
      retry_d = '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (host.tx_req) begin
            bo_d   = draw(lfsr_q, cw_q);
            difs_d = '0;
            st_d   = S_DIFS;
          end
        end
        S_DIFS: begin
          if (!host.tx_req) begin
            st_d   = S_IDLE;
            bo_d   = '0;
            difs_d = '0;
            slot_d = '0;
          end else if (carrier_present) begin
            difs_d = '0;
          end else if (difs_q == DIFS_LAST) begin
            difs_d = '0;
            slot_d = '0;
            st_d   = (bo_q == '0) ? S_TX : S_BACKOFF;
          end else begin
            difs_d = difs_q + 32'd1;
          end
        end
        S_BACKOFF: begin
          if (!host.tx_req) begin
            st_d   = S_IDLE;
            bo_d   = '0;
            difs_d = '0;
            slot_d = '0;
          end else if (carrier_present) begin
            // residual backoff survives; only the idle timers restart
            slot_d = '0;
            difs_d = '0;
            st_d   = S_DIFS;
          end else if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            bo_d   = bo_q - 10'd1;
            if (bo_q == 10'd1) st_d = S_TX;
          end else begin
            slot_d = slot_q + 16'd1;
          end
        end
        S_TX: begin
          if (host.tx_done) begin
            cw_d    = CW_MIN;
            retry_d = '0;
            st_d    = S_IDLE;
          end else if (host.tx_fail) begin
            if (retry_q == RETRY_MAX) begin
              drop_d  = 1'b1;
              cw_d    = CW_MIN;
              retry_d = '0;
              st_d    = S_IDLE;
            end else begin
              retry_d = retry_q + 4'd1;
              cw_d    = cw_inc;
              bo_d    = draw(lfsr_q, cw_inc);
              difs_d  = '0;
              st_d    = S_DIFS;
            end
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cw_q    <= CW_MIN;
      bo_q    <= '0;
      difs_q  <= '0;
      slot_q  <= '0;
      retry_q <= '0;
      lfsr_q  <= LFSR_SEED;
      grant_q <= 1'b0;
      csrun_q <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cw_q    <= cw_d;
      bo_q    <= bo_d;
      difs_q  <= difs_d;
      slot_q  <= slot_d;
      retry_q <= retry_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      grant_q <= (st_d == S_TX);
      csrun_q <= (st_d != S_TX);
      drop_q  <= drop_d;
    end
  end

  assign host.tx_grant   = grant_q;
  assign host.frame_drop = drop_q;
  assign host.retry_cnt  = retry_q;
  assign cs_run          = csrun_q;
  assign state           = st_q;

endmodule

// File: tb/tb_csma_tx_scheduler.sv
// Directed bench: two scheduler instances (CW_MIN_EXP 0 and 4) with a reference backoff LFSR.
module tb_csma_tx_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, en0, en1, cp0, cp1;
  logic cs_run0, cs_run1;
  logic [1:0] state0, state1;
  csma_tx_scheduler_if h0 ();
  csma_tx_scheduler_if h1 ();

  csma_tx_scheduler #(.SLOT_CYCLES(4), .DIFS_SLOTS(2), .CW_MIN_EXP(0), .CW_MAX_EXP(10),
                      .MAX_RETRIES(7), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .carrier_present(cp0),
    .host(h0.slave), .cs_run(cs_run0), .state(state0));

  csma_tx_scheduler #(.SLOT_CYCLES(4), .DIFS_SLOTS(2), .CW_MIN_EXP(4), .CW_MAX_EXP(10),
                      .MAX_RETRIES(2), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .carrier_present(cp1),
    .host(h1.slave), .cs_run(cs_run1), .state(state1));

  // Reference backoff LFSR for dut1 (taps 16,14,13,11)
  logic [15:0] m_lfsr;
  always @(posedge clk)
    if (rst1) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  int vec = 0;
  int errs = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pick(input logic [3:0] v);
    int n;
    n = 0;
    while (m_lfsr[3:0] != v && n < 200) begin
      step(1);
      n++;
    end
    if (m_lfsr[3:0] != v) begin
      errs++;
      $display("FAIL lfsr_pick: nibble %0h not reached", v);
    end
  endtask

  task automatic wait_grant1(input int lim, output int n);
    n = 1;
    while (!h1.tx_grant && n < lim) begin
      step(1);
      n++;
    end
  endtask

  int bo, n;

  initial begin
    rst0 = 1; rst1 = 1; en0 = 1; en1 = 1; cp0 = 0; cp1 = 0;
    h0.tx_req = 0; h0.tx_done = 0; h0.tx_fail = 0;
    h1.tx_req = 0; h1.tx_done = 0; h1.tx_fail = 0;
    step(2);
    chk("rst_state",  32'(state0), 0);
    chk("rst_grant",  32'(h0.tx_grant), 0);
    chk("rst_cs_run", 32'(cs_run0), 1);
    chk("rst_drop",   32'(h0.frame_drop), 0);
    chk("rst_retry",  32'(h0.retry_cnt), 0);
    chk("rst_state1", 32'(state1), 0);
    rst0 = 0; rst1 = 0;
    step(3);

    // Immediate grant: DIFS next cycle, grant DIFS_SLOTS*SLOT_CYCLES later
    h0.tx_req = 1;
    step(1);  chk("imm_difs", 32'(state0), 1);
    step(7);  chk("imm_no_grant_early", 32'(h0.tx_grant), 0);
    step(1);  chk("imm_grant", 32'(h0.tx_grant), 1);
    chk("imm_cs_run", 32'(cs_run0), 0);
    chk("imm_state_tx", 32'(state0), 3);
    h0.tx_done = 1; h0.tx_req = 0;
    step(1);  h0.tx_done = 0;
    chk("done_idle", 32'(state0), 0);
    chk("done_grant", 32'(h0.tx_grant), 0);
    chk("done_cs_run", 32'(cs_run0), 1);

    // DIFS restart: busy in cycles c0+4, c0+5
    h0.tx_req = 1;
    step(4);  cp0 = 1;
    step(1);  chk("difs_busy_no_grant", 32'(h0.tx_grant), 0);
    chk("difs_busy_state", 32'(state0), 1);
    step(1);  cp0 = 0;
    step(7);  chk("difs_restart_early", 32'(h0.tx_grant), 0);
    step(1);  chk("difs_restart_grant", 32'(h0.tx_grant), 1);

    // Simultaneous done+fail counts as success
    h0.tx_done = 1; h0.tx_fail = 1; h0.tx_req = 0;
    step(1);  h0.tx_done = 0; h0.tx_fail = 0;
    chk("both_state", 32'(state0), 0);
    chk("both_retry", 32'(h0.retry_cnt), 0);
    chk("both_drop",  32'(h0.frame_drop), 0);

    // Enable low while transmitting
    h0.tx_req = 1;
    step(9);  chk("en_pre_grant", 32'(h0.tx_grant), 1);
    en0 = 0;
    step(1);  chk("en_grant", 32'(h0.tx_grant), 0);
    chk("en_cs_run", 32'(cs_run0), 1);
    chk("en_state",  32'(state0), 0);
    en0 = 1; h0.tx_req = 0;

    // Backoff freeze with bo_cnt=3: busy in 2nd slot keeps residual 2
    pick(4'd3);
    h1.tx_req = 1;
    step(9);  chk("bo_enter", 32'(state1), 2);
    step(5);  cp1 = 1;
    step(1);  chk("bo_freeze_difs", 32'(state1), 1);
    cp1 = 0;
    step(7);  chk("bo_redifs", 32'(state1), 1);
    step(1);  chk("bo_resume", 32'(state1), 2);
    step(7);  chk("bo_no_grant_early", 32'(h1.tx_grant), 0);
    step(1);  chk("bo_grant", 32'(h1.tx_grant), 1);
    chk("bo_cs_run", 32'(cs_run1), 0);

    // Retry 1: cw_exp 5
    bo = int'(m_lfsr[4:0]);
    h1.tx_fail = 1;
    step(1);  h1.tx_fail = 0;
    chk("fail1_state", 32'(state1), 1);
    chk("fail1_retry", 32'(h1.retry_cnt), 1);
    chk("fail1_grant", 32'(h1.tx_grant), 0);
    wait_grant1(9 + 4 * bo + 20, n);
    chk("fail1_latency", 32'(n), 32'(9 + 4 * bo));

    // Retry 2: cw_exp 6
    bo = int'(m_lfsr[5:0]);
    h1.tx_fail = 1;
    step(1);  h1.tx_fail = 0;
    chk("fail2_retry", 32'(h1.retry_cnt), 2);
    wait_grant1(9 + 4 * bo + 20, n);
    chk("fail2_latency", 32'(n), 32'(9 + 4 * bo));

    // Third fail exceeds MAX_RETRIES=2 -> drop
    h1.tx_fail = 1; h1.tx_req = 0;
    step(1);  h1.tx_fail = 0;
    chk("drop_pulse", 32'(h1.frame_drop), 1);
    chk("drop_retry", 32'(h1.retry_cnt), 0);
    chk("drop_state", 32'(state1), 0);
    chk("drop_grant", 32'(h1.tx_grant), 0);
    step(1);  chk("drop_one_cycle", 32'(h1.frame_drop), 0);

    // After drop the window is back to 2^4
    bo = int'(m_lfsr[3:0]);
    h1.tx_req = 1;
    step(1);  chk("cwmin_difs", 32'(state1), 1);
    wait_grant1(9 + 4 * bo + 20, n);
    chk("cwmin_latency", 32'(n), 32'(9 + 4 * bo));
    h1.tx_done = 1; h1.tx_req = 0;
    step(1);  h1.tx_done = 0;
    chk("done1_state", 32'(state1), 0);

    // tx_req dropped in BACKOFF
    pick(4'd5);
    h1.tx_req = 1;
    step(9);  chk("abort_in_bo", 32'(state1), 2);
    h1.tx_req = 0;
    step(1);  chk("abort_idle", 32'(state1), 0);
    chk("abort_grant", 32'(h1.tx_grant), 0);

    // rst in BACKOFF
    pick(4'd3);
    h1.tx_req = 1;
    step(9);  chk("rst_in_bo", 32'(state1), 2);
    rst1 = 1; h1.tx_req = 0;
    step(1);
    chk("rstmid_state",  32'(state1), 0);
    chk("rstmid_grant",  32'(h1.tx_grant), 0);
    chk("rstmid_cs_run", 32'(cs_run1), 1);
    chk("rstmid_drop",   32'(h1.frame_drop), 0);
    chk("rstmid_retry",  32'(h1.retry_cnt), 0);
    rst1 = 0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
